// File: rtl/riscv_pert_cfg_master.sv
// Debug-bus initiator for the perturbation unit: queues register read/write commands
// and runs them one at a time on the req/gnt/rvalid port at base 0x0600.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops the FIFO head on exit
// REQ     | dbg_req_o high, waiting for dbg_gnt_i (or timeout)
// WAIT_RV | granted, waiting for dbg_rvalid_i (or timeout)
// RSP     | one-cycle response pulse, then back to IDLE
module riscv_pert_cfg_master #(
    parameter int CMD_DEPTH = 4,
    parameter int PERT_REGS = 15,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_idx_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_we_o,
    output logic [3:0]  rsp_idx_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        dbg_req_o,
    input  logic        dbg_gnt_i,
    input  logic        dbg_rvalid_i,
    output logic        dbg_we_o,
    output logic [14:0] dbg_addr_o,
    output logic [31:0] dbg_wdata_o,
    input  logic [31:0] dbg_rdata_i,
    output logic        busy_o
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 37;
    localparam logic [4:0]    PERT_REGS_W = 5'(PERT_REGS);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, RSP} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [CMD_DEPTH];
    logic [EW-1:0]     mem_d [CMD_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              cmd_we_q, cmd_we_d;
    logic [3:0]        cmd_idx_q, cmd_idx_d;
    logic [31:0]       cmd_wdata_q, cmd_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              push, pop, empty, full;
    logic [EW-1:0]     head;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(CMD_DEPTH));
    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    assign head        = mem_q[rd_ptr_q];
    assign busy_o      = (state_q != IDLE) || !empty;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {cmd_we_i, cmd_idx_i, cmd_wdata_i};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            cmd_we_q    <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            cmd_we_q    <= cmd_we_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Timeout counter restarts on entry to REQ and WAIT_RV and counts cycles spent there.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        tmo_d       = tmo_q;
        cmd_we_d    = cmd_we_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    cmd_we_d    = head[36];
                    cmd_idx_d   = head[35:32];
                    cmd_wdata_d = head[31:0];
                    rdata_d     = '0;
                    tmo_d       = '0;
                    if ({1'b0, head[35:32]} >= PERT_REGS_W) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dbg_gnt_i) begin
                    tmo_d   = '0;
                    state_d = WAIT_RV;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RSP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_RV: begin
                if (dbg_rvalid_i) begin
                    rdata_d = cmd_we_q ? 32'h0 : dbg_rdata_i;
                    state_d = RSP;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RSP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dbg_req_o   = 1'b0;
        dbg_we_o    = 1'b0;
        dbg_addr_o  = '0;
        dbg_wdata_o = '0;
        rsp_valid_o = 1'b0;
        rsp_we_o    = 1'b0;
        rsp_idx_o   = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        case (state_q)
            REQ: begin
                dbg_req_o   = 1'b1;
                dbg_we_o    = cmd_we_q;
                dbg_addr_o  = {1'b0, 6'b000110, 2'b00, cmd_idx_q, 2'b00};
                dbg_wdata_o = cmd_wdata_q;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                rsp_we_o    = cmd_we_q;
                rsp_idx_o   = cmd_idx_q;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_pert_cfg_master.sv
// Self-checking bench for riscv_pert_cfg_master: vector table of single commands plus
// hand-written FIFO-full, timeout and mid-transaction reset sequences, all scoreboarded.
module tb_riscv_pert_cfg_master;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [3:0]  cmd_idx_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_we_o, rsp_err_o;
    logic [3:0]  rsp_idx_o;
    logic [31:0] rsp_rdata_o;
    logic        dbg_req_o, dbg_gnt_i, dbg_rvalid_i, dbg_we_o;
    logic [14:0] dbg_addr_o;
    logic [31:0] dbg_wdata_o, dbg_rdata_i;
    logic        busy_o;

    riscv_pert_cfg_master #(.CMD_DEPTH(4), .PERT_REGS(15), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_idx_i(cmd_idx_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_idx_o(rsp_idx_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .dbg_req_o(dbg_req_o), .dbg_gnt_i(dbg_gnt_i), .dbg_rvalid_i(dbg_rvalid_i),
        .dbg_we_o(dbg_we_o), .dbg_addr_o(dbg_addr_o), .dbg_wdata_o(dbg_wdata_o),
        .dbg_rdata_i(dbg_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Responder: combinational grant, rvalid one cycle after the grant cycle.
    logic gnt_en = 1'b1;
    logic rv_en  = 1'b1;
    logic rv_flag = 1'b0;
    logic rv_drv  = 1'b0;
    logic [31:0] rd_val = 32'h0;
    assign dbg_gnt_i    = dbg_req_o && gnt_en;
    assign dbg_rvalid_i = rv_drv;
    assign dbg_rdata_i  = rd_val;
    always @(negedge clk) begin
        rv_drv  = rv_flag && rv_en;
        rv_flag = dbg_req_o && dbg_gnt_i;
    end

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] rdata;
        logic        err;
        int          push_cyc;
        int          lat;
        logic        has_bus;
        bus_t        bus;
    } exp_t;

    rsp_t obs_rsp[$];
    bus_t obs_bus[$];
    exp_t exp_q[$];
    int   req_total = 0;
    int   rsp_nz    = 0;

    always @(negedge clk) begin
        if (dbg_req_o) req_total++;
        if (dbg_req_o && dbg_gnt_i) obs_bus.push_back('{dbg_we_o, dbg_addr_o, dbg_wdata_o});
        if (rsp_valid_o)
            obs_rsp.push_back('{rsp_we_o, rsp_idx_o, rsp_rdata_o, rsp_err_o, cyc});
        else if (rsp_we_o || rsp_idx_o != 4'h0 || rsp_rdata_o != 32'h0 || rsp_err_o)
            rsp_nz++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the next negedge with cmd_valid_i dropped.
    task automatic push(input logic we, input logic [3:0] idx, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input logic exp_ready, input logic track);
        exp_t e;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_idx_i   = idx;
        cmd_wdata_i = wd;
        chk("cmd_ready", {31'h0, cmd_ready_o}, {31'h0, exp_ready});
        e.we = we; e.idx = idx; e.rdata = exp_rd; e.err = exp_err;
        e.push_cyc = cyc; e.lat = lat;
        e.has_bus = !exp_err;
        e.bus = '{we, 15'h0600 + {9'h0, idx, 2'b00}, wd};
        if (exp_ready && track) exp_q.push_back(e);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        rsp_t o;
        exp_t e;
        bus_t b;
        n = 0;
        while (obs_rsp.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (obs_rsp.size() == 0) begin
            chk("rsp_timeout", 32'(n), 32'(budget + 1));
            return;
        end
        o = obs_rsp.pop_front();
        if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(exp_q.size()), 32'h1);
            return;
        end
        e = exp_q.pop_front();
        chk("rsp_we", {31'h0, o.we}, {31'h0, e.we});
        chk("rsp_idx", {28'h0, o.idx}, {28'h0, e.idx});
        chk("rsp_rdata", o.rdata, e.rdata);
        chk("rsp_err", {31'h0, o.err}, {31'h0, e.err});
        if (e.lat != 0) chk("rsp_latency", 32'(o.cyc - e.push_cyc), 32'(e.lat));
        if (e.has_bus) begin
            if (obs_bus.size() == 0) begin
                chk("bus_missing", 32'h0, 32'h1);
            end else begin
                b = obs_bus.pop_front();
                chk("dbg_we", {31'h0, b.we}, {31'h0, e.bus.we});
                chk("dbg_addr", {17'h0, b.addr}, {17'h0, e.bus.addr});
                chk("dbg_wdata", b.wdata, e.bus.wdata);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rd_val;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_reqs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0;
        vecs[0] = '{1'b1, 4'd2,  32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1'b0, 4, 1};
        vecs[1] = '{1'b0, 4'd13, 32'h0,         32'h0000_001F, 32'h0000_001F, 1'b0, 4, 1};
        vecs[2] = '{1'b1, 4'd0,  32'hDEAD_BEEF, 32'h1111_1111, 32'h0,         1'b0, 4, 1};
        vecs[3] = '{1'b0, 4'd14, 32'h0,         32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 4, 1};
        vecs[4] = '{1'b1, 4'd15, 32'h0000_0077, 32'h0,         32'h0,         1'b1, 2, 0};
        vecs[5] = '{1'b0, 4'd15, 32'h0,         32'h5555_5555, 32'h0,         1'b1, 2, 0};
        vecs[6] = '{1'b0, 4'd7,  32'h0,         32'h0000_1234, 32'h0000_1234, 1'b0, 4, 1};

        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_idx_i = '0; cmd_wdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, cmd_ready_o}, 32'h1);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_req", {31'h0, dbg_req_o}, 32'h0);
        chk("rst_addr", {17'h0, dbg_addr_o}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            rd_val = vecs[i].rd_val;
            r0 = req_total;
            push(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].exp_rdata,
                 vecs[i].exp_err, vecs[i].exp_lat, 1'b1, 1'b1);
            wait_rsp(20);
            chk("req_cycles", 32'(req_total - r0), 32'(vecs[i].exp_reqs));
            repeat (2) @(negedge clk);
        end

        // FIFO full: one command is popped into the FSM, four more fill the FIFO.
        gnt_en = 1'b0;
        rd_val = 32'h0;
        for (int k = 0; k < 6; k++)
            push(1'b1, 4'(k + 1), 32'h100 + 32'(k), 32'h0, 1'b0, 0, k < 5, 1'b1);
        chk("full_ready", {31'h0, cmd_ready_o}, 32'h0);
        chk("full_busy", {31'h0, busy_o}, 32'h1);
        gnt_en = 1'b1;
        for (int k = 0; k < 5; k++) wait_rsp(40);
        repeat (3) @(negedge clk);
        chk("full_drained", 32'(obs_rsp.size()), 32'h0);
        chk("full_idle", {31'h0, busy_o}, 32'h0);

        // Grant timeout, then a normal command must still proceed.
        gnt_en = 1'b0;
        r0 = req_total;
        push(1'b0, 4'd5, 32'h0, 32'h0, 1'b1, 0, 1'b1, 1'b1);
        exp_q[exp_q.size() - 1].has_bus = 1'b0;
        wait_rsp(300);
        chk("timeout_req_cycles", 32'(req_total - r0), 32'd255);
        chk("timeout_no_grant", 32'(obs_bus.size()), 32'h0);
        gnt_en = 1'b1;
        rd_val = 32'hCAFE_0001;
        push(1'b0, 4'd6, 32'h0, 32'hCAFE_0001, 1'b0, 4, 1'b1, 1'b1);
        wait_rsp(20);
        repeat (2) @(negedge clk);

        // Reset while stuck in WAIT_RV with two commands queued behind it.
        rv_en = 1'b0;
        for (int k = 0; k < 3; k++) push(1'b1, 4'(k + 8), 32'h200 + 32'(k), 32'h0, 1'b0, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'h0, busy_o}, 32'h1);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        rv_en = 1'b1;
        obs_bus.delete();
        chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        chk("mid_rst_ready", {31'h0, cmd_ready_o}, 32'h1);
        chk("mid_rst_req", {31'h0, dbg_req_o}, 32'h0);
        r0 = req_total;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_rsp", 32'(obs_rsp.size()), 32'h0);
        chk("mid_rst_no_req", 32'(req_total - r0), 32'h0);
        rd_val = 32'h0000_0BAD;
        push(1'b0, 4'd1, 32'h0, 32'h0000_0BAD, 1'b0, 4, 1'b1, 1'b1);
        wait_rsp(20);

        chk("rsp_fields_zero_when_idle", 32'(rsp_nz), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
